mult_scheduler: RTL

MULT_SCHEDULER -- requirements
Module: mult_scheduler

---
 rtl/mult_scheduler.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/mult_scheduler.sv
// mult_scheduler: a two-requester front end to one shared 4x4 unsigned
// shift-and-add multiplier. Only one transaction is in flight at a time.
// Arbitration is round-robin when both requesters are valid in the same cycle.
//
// Ports
//   clk, rst                         clock; synchronous active-high reset
//   reqN_valid/_ready/_a/_b (N=0,1)  operand handshake, 4-bit unsigned A, B
//   resN_valid/_ready/_product       result handshake, 8-bit product A*B
//   busy                             high whenever the FSM is not IDLE
//
// Build option
//   MULT_EARLY_EXIT_EN  when defined, CALC leaves as soon as the remaining
//                       multiplier bits are all zero, which takes 1..4 cycles.
//                       When undefined, CALC always takes 4 cycles.
module mult_scheduler (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0_valid,
   output logic       req0_ready,
   input  logic [3:0] req0_a,
   input  logic [3:0] req0_b,
   input  logic       req1_valid,
   output logic       req1_ready,
   input  logic [3:0] req1_a,
   input  logic [3:0] req1_b,
   output logic       res0_valid,
   input  logic       res0_ready,
   output logic [7:0] res0_product,
   output logic       res1_valid,
   input  logic       res1_ready,
   output logic [7:0] res1_product,
   output logic       busy
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t     state_q, state_d;
   logic [7:0] acc_q, acc_d;
   logic [7:0] mcand_q, mcand_d;
   logic [3:0] mplier_q, mplier_d;
   logic [1:0] count_q, count_d;
   logic       owner_q, owner_d;
   logic       last_q, last_d;     // requester served most recently
   logic [7:0] prod0_q, prod0_d;
   logic [7:0] prod1_q, prod1_d;

   logic       grant;
   logic [7:0] acc_step;
   logic [3:0] mplier_sh;
   logic       exit_now;

   // On a tie the grant goes to whoever was not served last. With one valid
   // requester it simply wins.
   assign grant     = (req0_valid && req1_valid) ? ~last_q : req1_valid;
   assign acc_step  = acc_q + (mplier_q[0] ? mcand_q : 8'd0);
   assign mplier_sh = mplier_q >> 1;

`ifdef MULT_EARLY_EXIT_EN
   assign exit_now = (count_q == 2'd3) || (mplier_sh == 4'd0);
`else
   assign exit_now = (count_q == 2'd3);
`endif

   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      mcand_d    = mcand_q;
      mplier_d   = mplier_q;
      count_d    = count_q;
      owner_d    = owner_q;
      last_d     = last_q;
      prod0_d    = prod0_q;
      prod1_d    = prod1_q;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      case (state_q)
         IDLE: begin
            if (!rst) begin
               req0_ready = req0_valid && !grant;
               req1_ready = req1_valid && grant;
            end
            if (req0_ready || req1_ready) begin
               acc_d    = 8'd0;
               mcand_d  = {4'b0, (grant ? req1_a : req0_a)};
               mplier_d = grant ? req1_b : req0_b;
               count_d  = 2'd0;
               owner_d  = grant;
               state_d  = CALC;
            end
         end
         CALC: begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_sh;
            count_d  = count_q + 2'd1;
            // Product ports are latched on completion, so each port only
            // changes when its own requester finishes and then holds.
            if (exit_now) begin
               state_d = DONE;
               if (owner_q) prod1_d = acc_step;
               else         prod0_d = acc_step;
            end
         end
         DONE: begin
            if (owner_q ? res1_ready : res0_ready) begin
               state_d = IDLE;
               last_d  = owner_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         acc_q    <= 8'd0;
         mcand_q  <= 8'd0;
         mplier_q <= 4'd0;
         count_q  <= 2'd0;
         owner_q  <= 1'b0;
         last_q   <= 1'b1;
         prod0_q  <= 8'd0;
         prod1_q  <= 8'd0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         count_q  <= count_d;
         owner_q  <= owner_d;
         last_q   <= last_d;
         prod0_q  <= prod0_d;
         prod1_q  <= prod1_d;
      end
   end

   assign res0_valid   = (state_q == DONE) && !owner_q;
   assign res1_valid   = (state_q == DONE) && owner_q;
   assign res0_product = prod0_q;
   assign res1_product = prod1_q;
   assign busy         = (state_q != IDLE);

endmodule
